// File: rtl/nibble_add_seq.sv
// Sequential WIDTH-bit adder sharing one 4-bit ripple adder, one nibble per clock, LSB nibble first.
// Optional subtract mode enabled by defining NIBBLE_ADD_SEQ_SUB_EN.
module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[4];
endmodule

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    logic [3:0] b_nib;
    logic [3:0] s_nib;
    logic       c_nib;
    logic       init_carry;
    logic       accept;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic sub_reg, sub_next;

    // Two's-complement subtract: invert B at the adder input and start with carry 1.
    assign b_nib      = b_reg[3:0] ^ {4{sub_reg}};
    assign init_carry = sub ? 1'b1 : cin;
`else
    assign b_nib      = b_reg[3:0];
    assign init_carry = cin;
`endif

    adder4bit u_adder (
        .a    (a_reg[3:0]),
        .b    (b_nib),
        .cin  (carry_reg),
        .s    (s_nib),
        .cout (c_nib)
    );

    assign in_ready  = (state_reg == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN);
    assign sum       = sum_reg;
    assign cout      = carry_reg;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        sub_next   = sub_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    a_next     = op_a;
                    b_next     = op_b;
                    carry_next = init_carry;
                    sum_next   = '0;
                    cnt_next   = '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
                    sub_next   = sub;
`endif
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = a_reg >> 4;
                b_next     = b_reg >> 4;
                // New nibble enters at the top so the last step leaves nibble 0 at the bottom.
                sum_next   = sum_reg >> 4;
                sum_next[WIDTH-1 -: 4] = s_nib;
                carry_next = c_nib;
                if (cnt_reg == CW'(N - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub_reg   <= sub_next;
`endif
        end
    end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed scoreboard bench for nibble_add_seq (WIDTH=16); subtract steps run when NIBBLE_ADD_SEQ_SUB_EN is defined.
module tb_nibble_add_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int compared = 0;
    int mismatched = 0;
    logic [W:0] exp_q[$];

    nibble_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one transaction through accept and wait for the result; returns latency and busy cycles.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s, output int lat, output int busy_cycles);
        logic [W:0] e;
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        if (s) e = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   e = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic compare_result(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
            check({tag, "_cout"}, 32'(cout), 32'(e[W]));
        end
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
        int lat, bc;
        start_op(a, b, c, s, lat, bc);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        compare_result(tag);
        finish_handshake(tag);
        $display("op %s a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d lat=%0d", tag, a, b, c, s, sum, cout, lat);
    endtask

    initial begin
        int lat, bc, ov_seen;

        // Reset held for two edges.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset done");

        // Basic op with timing checks.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bc);
        check("basic_latency", 32'(lat), 32'd4);
        check("basic_busy_cycles", 32'(bc), 32'd4);
        check("basic_busy_in_done", 32'(busy), 32'd0);
        compare_result("basic");
        finish_handshake("basic");
        $display("op basic a=1234 b=4321 -> latency=%0d busy=%0d", lat, bc);

        run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("ripple2", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op("ripple3", 16'h9999, 16'h7777, 1'b1, 1'b0);
        run_op("mixed", 16'hA5C3, 16'h5A3C, 1'b1, 1'b0);

        // Backpressure in DONE with a stray in_valid pulse.
        start_op(16'h8421, 16'h1248, 1'b1, 1'b0, lat, bc);
        check("bp_latency", 32'(lat), 32'd4);
        begin
            logic [W:0] e;
            e = exp_q.pop_front();
            for (int i = 0; i < 5; i++) begin
                in_valid = (i == 2);
                op_a = 16'hDEAD; op_b = 16'hBEEF;
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_sum", 32'(sum), 32'(e[W-1:0]));
                check("bp_cout", 32'(cout), 32'(e[W]));
                check("bp_in_ready", 32'(in_ready), 32'd0);
                tick();
            end
            in_valid = 1'b0;
            check("bp_sum_end", 32'(sum), 32'(e[W-1:0]));
        end
        finish_handshake("bp");
        check("bp_not_accepted", 32'(busy), 32'd0);
        $display("op backpressure held 5 cycles");

        // Reset after two nibble steps discards the operation.
        op_a = 16'h3333; op_b = 16'h4444; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        check("midrst_no_result", 32'(ov_seen), 32'd0);
        $display("op mid-run reset discarded");
        run_op("after_rst", 16'h0101, 16'h0202, 1'b0, 1'b0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequential multi-word adder controller. It time-shares one `adder4bit` instance (ports `a`, `b`, `cin`, `s`, `cout`) to add WIDTH-bit operands one nibble per clock, least-significant nibble first. Operands arrive on a valid/ready input handshake, and the result leaves on a valid/ready output handshake. It sits between an operand producer and a result consumer wherever area matters more than adder throughput.

## Interface
- `WIDTH`, default 16: operand and sum width. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands and `cin` present.
- `in_ready`  out  1  block can accept; equals (state==IDLE) && rst_n.
- `op_a`  in  WIDTH  operand A.
- `op_b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in to nibble 0.
- `sub`  in  1  subtract request. Present only with `NIBBLE_ADD_SEQ_SUB_EN`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the top nibble.
- `busy`  out  1  state is RUN.

## Operation
- States: IDLE, RUN, DONE. The state encoding is implementation choice.
- **IDLE**
  - On in_valid && in_ready: latch op_a and op_b into shift registers and latch the carry register from `cin`.
  - Clear the sum shift register and the step counter to 0, then go to RUN.
  - Operand inputs are ignored after acceptance.
- **RUN**
  - Each cycle, the `adder4bit` takes the low nibble of A, the low nibble of B, and the carry register.
  - A and B shift right by 4.
  - `s` enters `sum` at bit WIDTH-1 and `sum` shifts right by 4.
  - The carry register takes `cout`, and the counter increments.
  - When counter == N-1, go to DONE on that edge.
- **DONE**
  - `out_valid`=1; `sum` and `cout` (from the carry register) are held stable.
  - On out_ready: go to IDLE.
  - No operand acceptance in DONE, because `in_ready`=0.
- Arithmetic:
  - sum = (op_a + op_b + cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - No overflow flag.
- `sum` is only meaningful while `out_valid`=1. During RUN it shows partial shift contents.
- Reset values, applied by the first edge with rst_n=0 from any state (including mid-RUN, where the operation is discarded with no result):
  - state IDLE
  - `out_valid`=0, `sum`=0, `cout`=0, `busy`=0
  - `in_ready`=0 while rst_n=0, and 1 afterwards
  - counter and operand registers 0
- `in_valid` held high while `in_ready`=0 has no effect and is not queued.

## Timing
- Edge E0: accept.
- Edges E1..EN: nibbles 0..N-1 processed.
- `out_valid` is high after EN. Latency from accept to out_valid is N cycles.
- `busy` is high after E0 through EN.
- The output handshake completes on the edge where out_valid && out_ready. `in_ready` rises after that edge.
- Minimum period between accepts is N+2 cycles with `out_ready` tied high.
- WIDTH=4 (N=1): RUN lasts exactly one cycle.
- The counter wraps only through the DONE→IDLE path and never runs past N-1.

## Configuration
- `NIBBLE_ADD_SEQ_SUB_EN` defined:
  - The `sub` port exists and is latched on accept.
  - When sub=1, every B nibble is bitwise inverted before the adder and the initial carry is forced to 1, ignoring `cin`.
  - Result is (op_a − op_b) mod 2^WIDTH; `cout`=1 means no borrow.
  - When sub=0, behaviour is identical to add.
- Not defined: no `sub` port and no inversion logic; add only.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → out_valid=0, sum=0, cout=0, busy=0, in_ready=0. After release, in_ready=1.
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid rises exactly 4 edges after accept, and busy is high for 4 cycles.
- Full carry ripple:
  - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1.
  - a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
  - a=0x9999, b=0x7777, cin=1 → sum=0x1111, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum and cout stay stable. in_valid pulsed high meanwhile is not accepted. Raising out_ready → IDLE next edge.
- Reset mid-op: assert rst_n=0 for one edge after 2 nibble steps → IDLE with out_valid never asserted for that operation. A following op a=0x0101, b=0x0202 → sum=0x0303.
- With `NIBBLE_ADD_SEQ_SUB_EN`:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0.
  - a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
